// File: rtl/ltc2324_axis_tx.sv
// LTC2324 frame FIFO + AXI4-Stream master, two 32-bit beats per frame.
// Define LTC2324_AXIS_TUSER_EN for an 8-bit frame sequence on m_axis_tuser.
module ltc2324_axis_tx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FRAMES_PER_PKT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        s_valid,
  input  logic [15:0] ch1,
  input  logic [15:0] ch2,
  input  logic [15:0] ch3,
  input  logic [15:0] ch4,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
`ifdef LTC2324_AXIS_TUSER_EN
  output logic [7:0]  m_axis_tuser,
`endif
  output logic        overflow,
  output logic [15:0] drop_cnt,
  input  logic        clear_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef LTC2324_AXIS_TUSER_EN
  localparam int EW = 72;
`else
  localparam int EW = 64;
`endif
  localparam logic [AW:0] FULL_CNT =
    (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] LAST_CNT =
    16'(FRAMES_PER_PKT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic [EW-1:0] r_out;
  logic [15:0]   r_fcnt;
  logic          r_ovf;
  logic [15:0]   r_drops;
  logic [EW-1:0] w_wdata;
  logic          w_acc;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_hs;

`ifdef LTC2324_AXIS_TUSER_EN
  logic [7:0] r_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= '0;
    end else if (w_push) begin
      r_seq <= r_seq + 8'd1;
    end
  end

  assign w_wdata = {r_seq, ch4, ch3, ch2, ch1};
  assign m_axis_tuser = r_out[71:64];
`else
  assign w_wdata = {ch4, ch3, ch2, ch1};
`endif

  // Fullness uses the pre-pop count, so a pop never rescues a frame.
  assign w_acc   = s_valid & enable;
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);
  assign w_push  = w_acc & ~w_full;
  assign w_drop  = w_acc & w_full;
  assign w_hs    = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_next = S_BEAT0;
          w_pop  = 1'b1;
        end
      end
      S_BEAT0: begin
        if (w_hs) begin
          w_next = S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (w_hs) begin
          if (!w_empty) begin
            w_next = S_BEAT0;
            w_pop  = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_pop) begin
        r_out <= r_mem[r_rptr];
      end
      if (w_hs && r_state == S_BEAT1) begin
        if (r_fcnt == LAST_CNT) begin
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 16'd1;
        end
      end
    end
  end

  // A drop coinciding with clear wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end else if (clear_ovf) begin
      r_ovf   <= w_drop;
      r_drops <= {15'd0, w_drop};
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drops != 16'hFFFF) begin
        r_drops <= r_drops + 16'd1;
      end
    end
  end

  assign m_axis_tvalid = (r_state != S_IDLE);
  assign m_axis_tdata  = (r_state == S_BEAT1) ?
                         r_out[63:32] : r_out[31:0];
  assign m_axis_tlast  = (r_state == S_BEAT1) &&
                         (r_fcnt == LAST_CNT);
  assign overflow      = r_ovf;
  assign drop_cnt      = r_drops;

endmodule

// File: tb/tb_ltc2324_axis_tx.sv
// Bench for ltc2324_axis_tx: directed steps plus random traffic
// checked against a frame-queue model of the stream.
module tb_ltc2324_axis_tx;

  localparam int DEPTH = 8;
  localparam int FPP   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        s_valid;
  logic [15:0] ch1, ch2, ch3, ch4;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        ovf;
  logic [15:0] dcnt;
  logic        clear_ovf;
`ifdef LTC2324_AXIS_TUSER_EN
  logic [7:0]  tuser;
`endif

  ltc2324_axis_tx #(
    .FIFO_DEPTH(DEPTH),
    .FRAMES_PER_PKT(FPP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .s_valid(s_valid),
    .ch1(ch1),
    .ch2(ch2),
    .ch3(ch3),
    .ch4(ch4),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast(tlast),
`ifdef LTC2324_AXIS_TUSER_EN
    .m_axis_tuser(tuser),
`endif
    .overflow(ovf),
    .drop_cnt(dcnt),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  u;
  } frm_t;

  frm_t       exp_q[$];
  int         total  = 0;
  int         bad    = 0;
  int         beat   = 0;
  int         fidx   = 0;
  int         n_last = 0;
  logic [7:0] seq    = 8'd0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: inputs change just after posedge,
  // so a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      beat   = 0;
      fidx   = 0;
      n_last = 0;
    end else if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected beat", 64'(tdata), 64'hDEAD);
      end else begin
`ifdef LTC2324_AXIS_TUSER_EN
        check("tuser", 64'(tuser), 64'(exp_q[0].u));
`endif
        if (beat == 0) begin
          check("beat0 data", 64'(tdata),
                64'(exp_q[0].d[31:0]));
          check("beat0 tlast", 64'(tlast), 64'd0);
          beat = 1;
        end else begin
          check("beat1 data", 64'(tdata),
                64'(exp_q[0].d[63:32]));
          check("beat1 tlast", 64'(tlast),
                64'((fidx % FPP) == FPP - 1));
          if (tlast) n_last++;
          fidx++;
          void'(exp_q.pop_front());
          beat = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rtick();
    tready = ($urandom_range(0, 3) != 0);
    tick();
  endtask

  task automatic send(input logic [15:0] a, b, c, d,
                      input bit en, input bit acc);
    enable  = en;
    ch1     = a;
    ch2     = b;
    ch3     = c;
    ch4     = d;
    s_valid = 1'b1;
    if (acc) begin
      exp_q.push_back('{{d, c, b, a}, seq});
      seq++;
    end
    tick();
    s_valid = 1'b0;
    enable  = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    tready = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    tick();
    check({tag, " idle"}, 64'(tvalid), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!tvalid && n < 10) begin
      tick();
      n++;
    end
    check(tag, 64'(tvalid), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seq   = 8'd0;
    tick();
    tick();
    check("rst tvalid", 64'(tvalid), 64'd0);
    check("rst tdata", 64'(tdata), 64'd0);
    check("rst tlast", 64'(tlast), 64'd0);
    check("rst ovf", 64'(ovf), 64'd0);
    check("rst dcnt", 64'(dcnt), 64'd0);
    rst_n = 1'b1;
    tick();
  endtask

  logic [31:0] hold_d;
  logic        hold_l;
  int          wn;
  bit          en;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    s_valid   = 1'b0;
    tready    = 1'b1;
    clear_ovf = 1'b0;
    ch1 = '0; ch2 = '0; ch3 = '0; ch4 = '0;
    do_reset();

    // single frame latency
    send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 1);
    check("lat N+1 tvalid", 64'(tvalid), 64'd0);
    tick();
    check("lat N+2 tvalid", 64'(tvalid), 64'd1);
    check("lat N+2 tdata", 64'(tdata), 64'h22221111);
    tick();
    check("lat N+3 tdata", 64'(tdata), 64'h44443333);
    check("lat N+3 tlast", 64'(tlast), 64'd0);
    drain("single drain");

    // packet framing
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(16'(i), 16'(i + 100), 16'(i + 200),
           16'(i + 300), 1, 1);
      repeat ($urandom_range(1, 3)) tick();
    end
    drain("frame drain");
    check("tlast count", 64'(n_last), 64'd2);

    // backpressure stability
    tready = 1'b0;
    send(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1, 1);
    wait_valid("bp rise");
    hold_d = tdata;
    hold_l = tlast;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp tdata", 64'(tdata), 64'(hold_d));
      check("bp tlast", 64'(tlast), 64'(hold_l));
    end
    drain("bp drain");

    // overflow: 1 in output reg, 8 queued, 2 dropped
    tready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      send(16'(16'hA000 + i), 16'(16'hB000 + i),
           16'(16'hC000 + i), 16'(16'hD000 + i),
           1, i < 9);
      tick();
    end
    check("ovf flag", 64'(ovf), 64'd1);
    check("ovf count", 64'(dcnt), 64'd2);
    clear_ovf = 1'b1;
    send(16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hEEEE, 1, 0);
    clear_ovf = 1'b0;
    check("clr+drop flag", 64'(ovf), 64'd1);
    check("clr+drop count", 64'(dcnt), 64'd1);
    drain("ovf drain");
    check("ovf hold", 64'(dcnt), 64'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr flag", 64'(ovf), 64'd0);
    check("clr count", 64'(dcnt), 64'd0);

    // enable gate
    for (int i = 0; i < 3; i++) begin
      send(16'h5555, 16'h6666, 16'h7777, 16'h8888, 0, 0);
      tick();
      check("en0 tvalid", 64'(tvalid), 64'd0);
    end
    check("en0 dcnt", 64'(dcnt), 64'd0);
    check("en0 ovf", 64'(ovf), 64'd0);

    // random traffic, never more outstanding than fit
    for (int k = 0; k < 60; k++) begin
      wn = 0;
      while (exp_q.size() >= DEPTH && wn < 500) begin
        rtick();
        wn++;
      end
      check("rand wait", 64'(wn < 500), 64'd1);
      repeat ($urandom_range(0, 3)) rtick();
      en = ($urandom_range(0, 7) != 0);
      send(16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), en, en);
    end
    drain("rand drain");
    check("rand dcnt", 64'(dcnt), 64'd0);

    // async reset while in BEAT1
    tready = 1'b0;
    send(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1, 1);
    wait_valid("rst rise");
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("beat1 held", 64'(tdata), 64'hCDEF89AB);
    #2;
    rst_n = 1'b0;
    seq   = 8'd0;
    #1;
    check("async tvalid", 64'(tvalid), 64'd0);
    check("async tdata", 64'(tdata), 64'd0);
    tick();
    tick();
    rst_n  = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post rst empty", 64'(tvalid), 64'd0);
    end
    send(16'h0F0F, 16'hF0F0, 16'h1234, 16'h5678, 1, 1);
    drain("post rst drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
